alu_nibble_seq: RTL and testbench
=================================

Name: alu_nibble_seq

Overview:
- Multi-cycle W-bit ALU front end that drives one 4-bit ALU slice.
- Accepts a W-bit operation request over a valid/ready handshake.
- Processes the operands one nibble per clock, LSB first, chaining the carry between nibbles.
- Returns the W-bit result and flags over a second valid/ready handshake.
- Sits between the NPC operand source and the consumer of ALU results; it is the sequencing end of the 4-bit ALU's opcode/flag interface.

Parameters:
- W, 16: operand width in bits; must be a multiple of 4 and at least 4.
- N, W/4: nibble count; derived, not overridable.

Ports:
- clk  in  1  system clock; rising-edge.
- rst_n  in  1  synchronous active-low reset, sampled on the clk rising edge.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  3  operation code (see Behaviour).
- req_a  in  W  operand a.
- req_b  in  W  operand b.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer accepts the result.
- rsp_result  out  W  result.
- rsp_zero  out  1  result == 0.
- rsp_overflow  out  1  signed overflow.
- rsp_carry  out  1  carry out of the MSB.
- rsp_size  out  1  compare outcome.

Behaviour:
- Opcodes:
  - 000 add: a+b.
  - 001 sub: a-b.
  - 010 not: ~a.
  - 011 and.
  - 100 or.
  - 101 xor.
  - 110 signed less-than: result = a-b.
  - 111 equal: result = a-b.
- Subtract-class ops (001/110/111) use a + ~b + 1: carry-in to nibble 0 is 1 and b is inverted nibble-wise. Add uses carry-in 0.
- FSM states IDLE, RUN, DONE.
  - Reset: IDLE, req_ready=1, rsp_valid=0, every rsp_* output = 0, nibble index = 0.
  - IDLE: req_ready=1. When req_valid&&req_ready, latch op, a and b, set index=0, set the initial carry, go to RUN.
  - RUN: req_ready=0. Each cycle the slice processes nibble[index] and writes result nibble[index]; the carry register updates. When index==N-1, write the final nibble, compute the flags, go to DONE; otherwise index++.
  - DONE: rsp_valid=1. rsp_* outputs stay stable until rsp_valid&&rsp_ready, then go to IDLE. rsp_valid drops the cycle after the handshake.
- Latency:
  - Exactly N rising edges from the accepting edge to rsp_valid high (4 for W=16, 1 for W=4).
  - Throughput is one operation per N+2 cycles minimum.
  - No request is accepted while RUN or DONE. A new request is accepted no earlier than the cycle after the response handshake.
- Flags, computed at the last nibble:
  - zero = ~|result, for all ops.
  - carry = carry out of bit W-1 for 000/001/110/111, else 0. For subtract, carry=1 means no borrow.
  - overflow = for add (a[W-1]==b[W-1])&&(r[W-1]!=a[W-1]); for subtract-class, computed the same way with ~b in place of b; logic ops give 0.
  - size = for 110, r[W-1]^overflow (1 iff a<b signed); for 111, zero (1 iff a==b); all other ops 0.
- Logic ops still take N cycles (uniform latency); the carry chain is ignored for them.
- Reset asserted in any state returns to IDLE on that edge. Any in-flight operation is discarded, with no partial response, and all outputs return to their reset values.
- req_* inputs are ignored outside the IDLE accept cycle; the latched copies are used.
- Undefined opcodes: none exist, since all 8 codes are defined.

Decomposition:
- Shared include header: opcode constants (OP_ADD..OP_EQ) and the FSM state encoding.
- One sub-module, alu_slice4, purely combinational. It takes a 4-bit a nibble, a 4-bit b nibble (already inverted for subtract-class ops), carry-in and op. It returns the 4-bit result, carry-out, and overflow computed on its own MSB.
- The top level keeps the FSM, the operand shift or index mux, the result assembly and the flags. Only the top slice's overflow is used.

Test Plan:
- add a=0x7FFF b=0x0001 -> result 0x8000, overflow=1, carry=0, zero=0, size=0; rsp_valid exactly 4 edges after accept.
- sub a=0x0000 b=0x0001 -> result 0xFFFF, carry=0, overflow=0. Then sub a=0x0005 b=0x0005 -> result 0x0000, zero=1, carry=1.
- op 110 a=0x8000 b=0x0001 -> result 0x7FFF, overflow=1, size=1. Then a=0x0003 b=0xFFFE -> size=0.
- op 111 a=b=0x1234 -> zero=1, size=1. Then a=0x1234 b=0x1235 -> size=0. Also op 010 a=0x00FF -> result 0xFF00, carry=0, overflow=0.
- Backpressure: hold rsp_ready=0 for 3 cycles in DONE -> rsp_* stable and req_ready=0. A pending req_valid is not accepted until the cycle after the rsp handshake.
- rst_n=0 on the 2nd RUN cycle -> next cycle state IDLE, req_ready=1, rsp_valid=0, all rsp_* = 0. No response is ever produced for the aborted request.

Source files
------------

// File: rtl/alu_nibble_seq_pkg.sv
// alu_nibble_seq_pkg: opcodes, FSM states and op-class helpers shared by the nibble ALU
package alu_nibble_seq_pkg;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_NOT, OP_AND, OP_OR, OP_XOR, OP_LT, OP_EQ} op_e;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  function automatic logic is_sub(op_e op);
    return op == OP_SUB || op == OP_LT || op == OP_EQ;
  endfunction
  function automatic logic is_arith(op_e op);
    return is_sub(op) || op == OP_ADD;
  endfunction
endpackage

// File: rtl/alu_slice4.sv
// alu_slice4: combinational 4-bit ALU slice; b arrives pre-inverted for subtract-class ops
module alu_slice4
  import alu_nibble_seq_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  input  op_e        op,
  output logic [3:0] r,
  output logic       co,
  output logic       ovf
);
  logic [4:0] s;
  always_comb begin
    s   = {1'b0, a} + {1'b0, b} + {4'b0, ci};
    r   = op == OP_NOT ? ~a : op == OP_AND ? a & b : op == OP_OR ? a | b : op == OP_XOR ? a ^ b : s[3:0];
    co  = is_arith(op) & s[4];
    ovf = is_arith(op) & (a[3] == b[3]) & (s[3] != a[3]);
  end
endmodule

// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq: W-bit ALU sequenced one nibble per cycle through a single 4-bit slice
module alu_nibble_seq
  import alu_nibble_seq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic         rsp_zero,
  output logic         rsp_overflow,
  output logic         rsp_carry,
  output logic         rsp_size
);
  localparam int N  = W / 4;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  state_e         state, state_n;
  op_e            op;
  logic [W-1:0]   a, b, res_n;
  logic [IW-1:0]  idx;
  logic           c, last, sco, sovf;
  logic [3:0]     an, bn, sr;
  alu_slice4 u_slice (.a(an), .b(bn), .ci(c), .op(op), .r(sr), .co(sco), .ovf(sovf));
  always_comb begin
    an            = a[idx*4 +: 4];
    bn            = is_sub(op) ? ~b[idx*4 +: 4] : b[idx*4 +: 4];
    res_n         = rsp_result;
    res_n[idx*4 +: 4] = sr;
    last          = idx == IW'(N - 1);
    req_ready     = state == IDLE;
    rsp_valid     = state == DONE;
    state_n       = state == IDLE ? (req_valid ? RUN : IDLE) :
                    state == RUN  ? (last ? DONE : RUN) :
                    (rsp_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op           <= OP_ADD;
      a            <= '0;
      b            <= '0;
      idx          <= '0;
      c            <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_carry    <= 1'b0;
      rsp_size     <= 1'b0;
    end else if (state == IDLE && req_valid) begin
      op  <= op_e'(req_op);
      a   <= req_a;
      b   <= req_b;
      idx <= '0;
      c   <= is_sub(op_e'(req_op));
    end else if (state == RUN) begin
      rsp_result <= res_n;
      c          <= sco;
      idx        <= idx + 1'b1;
      // Only the top slice's carry/overflow describe the full-width result
      if (last) begin
        rsp_zero     <= ~|res_n;
        rsp_carry    <= sco;
        rsp_overflow <= sovf;
        rsp_size     <= op == OP_LT ? res_n[W-1] ^ sovf : (op == OP_EQ) & ~|res_n;
      end
    end
  end
endmodule

// File: tb/tb_alu_nibble_seq.sv
// tb_alu_nibble_seq: directed plus random checking of alu_nibble_seq against an arithmetic model
module tb_alu_nibble_seq;
  localparam int W = 16;
  localparam int N = W / 4;
  logic         clk = 0, rst_n = 0, req_valid = 0, rsp_ready = 0;
  logic [2:0]   req_op = 0;
  logic [W-1:0] req_a = 0, req_b = 0;
  logic         req_ready, rsp_valid, rsp_zero, rsp_overflow, rsp_carry, rsp_size;
  logic [W-1:0] rsp_result;
  int           n_chk = 0, n_fail = 0;
  alu_nibble_seq #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
    .rsp_carry(rsp_carry), .rsp_size(rsp_size)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // returns {size, overflow, carry, zero, result}
  function automatic logic [W+3:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic sub, arith, ovf, sz;
    logic [W-1:0] bb, r;
    logic [W:0] sum;
    sub   = op == 3'd1 || op == 3'd6 || op == 3'd7;
    arith = sub || op == 3'd0;
    bb    = sub ? ~b : b;
    sum   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
    case (op)
      3'd2: r = ~a;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      default: r = sum[W-1:0];
    endcase
    ovf = arith && (a[W-1] == bb[W-1]) && (sum[W-1] != a[W-1]);
    sz  = op == 3'd6 ? ($signed(a) < $signed(b)) : op == 3'd7 ? (a == b) : 1'b0;
    return {sz, ovf, arith & sum[W], r == 0, r};
  endfunction
  task automatic check_rsp(input string tag, input logic [W+3:0] e);
    check({tag, ".result"}, 32'(rsp_result), 32'(e[W-1:0]));
    check({tag, ".zero"}, 32'(rsp_zero), 32'(e[W]));
    check({tag, ".carry"}, 32'(rsp_carry), 32'(e[W+1]));
    check({tag, ".ovf"}, 32'(rsp_overflow), 32'(e[W+2]));
    check({tag, ".size"}, 32'(rsp_size), 32'(e[W+3]));
  endtask
  task automatic check_idle(input string tag);
    check({tag, ".req_ready"}, 32'(req_ready), 1);
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, ".rsp"}, 32'({rsp_result, rsp_zero, rsp_overflow, rsp_carry, rsp_size}), 0);
  endtask
  // One transaction: accept, scramble req_* while running, hold the response, then handshake.
  task automatic run(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold, input bit pend);
    logic [W+3:0] e;
    int k, lat;
    e = model(op, a, b);
    req_op = op; req_a = a; req_b = b; req_valid = 1;
    k = 0;
    while (!req_ready && k < 50) begin @(posedge clk); #1; k++; end
    if (!req_ready) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 0; req_op = 3'($urandom); req_a = W'($urandom); req_b = W'($urandom);
    lat = 0;
    while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    check("latency", 32'(lat), N);
    check_rsp("rsp", e);
    if (pend) req_valid = 1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold.req_ready", 32'(req_ready), 0);
      check("hold.rsp_valid", 32'(rsp_valid), 1);
      check_rsp("hold", e);
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    check("post.rsp_valid", 32'(rsp_valid), 0);
    check("post.req_ready", 32'(req_ready), 1);
  endtask
  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    #1 check_idle("reset");
    rst_n = 1;
    @(posedge clk); #1;
    run(3'd0, 16'h7FFF, 16'h0001, 0, 0);
    run(3'd1, 16'h0000, 16'h0001, 0, 0);
    run(3'd1, 16'h0005, 16'h0005, 1, 0);
    run(3'd6, 16'h8000, 16'h0001, 0, 0);
    run(3'd6, 16'h0003, 16'hFFFE, 0, 0);
    run(3'd7, 16'h1234, 16'h1234, 0, 0);
    run(3'd7, 16'h1234, 16'h1235, 0, 0);
    run(3'd2, 16'h00FF, 16'h0000, 0, 0);
    run(3'd5, 16'hA5A5, 16'h0FF0, 3, 1);
    run(3'd3, 16'hF0F0, 16'hFF00, 0, 0);
    req_op = 3'd0; req_a = 16'h1111; req_b = 16'h2222; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk);
    rst_n = 0;
    @(posedge clk); #1;
    check_idle("abort");
    rst_n = 1;
    seen = 0;
    for (int i = 0; i < N + 4; i++) begin @(posedge clk); #1; seen |= rsp_valid; end
    check("abort.no_rsp", 32'(seen), 0);
    for (int i = 0; i < 300; i++)
      run(3'($urandom), W'($urandom), $urandom_range(0, 7) == 0 ? W'(0) : W'($urandom),
          $urandom_range(0, 2), 1'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
